// File: rtl/mdio_status_poller.sv
// Clause 22 MDIO poller: periodically reads BMSR, PHYID1 and PHYID2 and publishes them atomically.
// Optional MDIO_BMSR_DOUBLE_READ_EN reads BMSR twice per sequence so its latched-low bits are current.
module mdio_status_poller #(
  parameter int unsigned CLK_DIV    = 25,
  parameter logic [4:0]  PHY_ADDR   = 5'd1,
  parameter int unsigned POLL_TICKS = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  output logic [15:0] bmsr,
  output logic [15:0] phyid_1,
  output logic [15:0] phyid_2,
  output logic        upd,
  output logic        err,
  output logic        busy
);

  localparam int unsigned HW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PW        = $clog2(POLL_TICKS + 1);
  localparam int unsigned PRE_BITS  = 32;
  localparam int unsigned HDR_BITS  = 14;
  localparam int unsigned TA_BITS   = 2;
  localparam int unsigned DATA_BITS = 16;
`ifdef MDIO_BMSR_DOUBLE_READ_EN
  localparam int unsigned NFRAMES   = 4;
`else
  localparam int unsigned NFRAMES   = 3;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_NEXT
  } state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   hcnt, hcnt_nxt;
  logic [4:0]      bcnt, bcnt_nxt;
  logic [1:0]      fidx, fidx_nxt;
  logic [PW-1:0]   poll_cnt, poll_cnt_nxt;
  logic [13:0]     hdr_sr, hdr_sr_nxt;
  logic [15:0]     data_sr, data_sr_nxt;
  logic            nores, nores_nxt;
  logic [15:0]     hold1, hold1_nxt;
  logic [15:0]     hold2, hold2_nxt;
  logic [15:0]     hold3, hold3_nxt;
  logic            mdio_s1, mdio_s2;

  logic            mdc_nxt, mdio_o_nxt, mdio_oe_nxt;
  logic [15:0]     bmsr_nxt, phyid_1_nxt, phyid_2_nxt;
  logic            upd_nxt, err_nxt, busy_nxt;

  logic [1:0]      regad;
  logic            half_end, bit_end, last_frame, poll_due;
  logic [13:0]     hdr_word;
  logic [15:0]     frame_val;
  logic [15:0]     hold1_w, hold2_w, hold3_w;

  // Register address of the current frame
  always_comb begin
`ifdef MDIO_BMSR_DOUBLE_READ_EN
    regad = (fidx == 2'd0) ? 2'd1 : fidx;
`else
    regad = fidx + 2'd1;
`endif
  end

  assign half_end   = (hcnt == HW'(CLK_DIV - 1));
  assign bit_end    = half_end && mdc;
  assign last_frame = (fidx == 2'(NFRAMES - 1));
  assign poll_due   = (poll_cnt == PW'(POLL_TICKS - 1));
  assign hdr_word   = {2'b01, 2'b10, PHY_ADDR, 3'b000, regad};
  assign frame_val  = nores ? 16'hFFFF : data_sr;
  assign hold1_w    = (regad == 2'd1) ? frame_val : hold1;
  assign hold2_w    = (regad == 2'd2) ? frame_val : hold2;
  assign hold3_w    = (regad == 2'd3) ? frame_val : hold3;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      hcnt     <= '0;
      bcnt     <= '0;
      fidx     <= '0;
      poll_cnt <= '0;
      hdr_sr   <= '0;
      data_sr  <= '0;
      nores    <= 1'b0;
      hold1    <= '0;
      hold2    <= '0;
      hold3    <= '0;
      mdio_s1  <= 1'b1;
      mdio_s2  <= 1'b1;
      mdc      <= 1'b0;
      mdio_o   <= 1'b1;
      mdio_oe  <= 1'b0;
      bmsr     <= '0;
      phyid_1  <= '0;
      phyid_2  <= '0;
      upd      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hcnt     <= hcnt_nxt;
      bcnt     <= bcnt_nxt;
      fidx     <= fidx_nxt;
      poll_cnt <= poll_cnt_nxt;
      hdr_sr   <= hdr_sr_nxt;
      data_sr  <= data_sr_nxt;
      nores    <= nores_nxt;
      hold1    <= hold1_nxt;
      hold2    <= hold2_nxt;
      hold3    <= hold3_nxt;
      mdio_s1  <= mdio_i;
      mdio_s2  <= mdio_s1;
      mdc      <= mdc_nxt;
      mdio_o   <= mdio_o_nxt;
      mdio_oe  <= mdio_oe_nxt;
      bmsr     <= bmsr_nxt;
      phyid_1  <= phyid_1_nxt;
      phyid_2  <= phyid_2_nxt;
      upd      <= upd_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state, MDC generation and frame sequencing
  always_comb begin
    state_nxt    = state;
    hcnt_nxt     = hcnt;
    bcnt_nxt     = bcnt;
    fidx_nxt     = fidx;
    poll_cnt_nxt = poll_cnt;
    hdr_sr_nxt   = hdr_sr;
    data_sr_nxt  = data_sr;
    nores_nxt    = nores;
    hold1_nxt    = hold1;
    hold2_nxt    = hold2;
    hold3_nxt    = hold3;
    mdc_nxt      = mdc;
    mdio_o_nxt   = mdio_o;
    mdio_oe_nxt  = mdio_oe;
    bmsr_nxt     = bmsr;
    phyid_1_nxt  = phyid_1;
    phyid_2_nxt  = phyid_2;
    upd_nxt      = 1'b0;
    err_nxt      = err;
    busy_nxt     = busy;

    // MDC half-period counter runs only while a frame is on the wire
    if (state == S_PRE || state == S_HDR || state == S_TA || state == S_DATA) begin
      if (half_end) begin
        hcnt_nxt = '0;
        mdc_nxt  = ~mdc;
      end else begin
        hcnt_nxt = hcnt + HW'(1);
      end
    end

    case (state)
      S_IDLE: begin
        hcnt_nxt = '0;
        mdc_nxt  = 1'b0;
        if (start || poll_due) begin
          state_nxt    = S_PRE;
          poll_cnt_nxt = '0;
          fidx_nxt     = '0;
          bcnt_nxt     = '0;
          err_nxt      = 1'b0;
          busy_nxt     = 1'b1;
          mdio_o_nxt   = 1'b1;
          mdio_oe_nxt  = 1'b1;
        end else begin
          poll_cnt_nxt = poll_cnt + PW'(1);
        end
      end

      S_PRE: begin
        if (bit_end) begin
          if (bcnt == 5'(PRE_BITS - 1)) begin
            state_nxt  = S_HDR;
            bcnt_nxt   = '0;
            mdio_o_nxt = hdr_word[13];
            hdr_sr_nxt = {hdr_word[12:0], 1'b0};
          end else begin
            bcnt_nxt = bcnt + 5'd1;
          end
        end
      end

      S_HDR: begin
        if (bit_end) begin
          if (bcnt == 5'(HDR_BITS - 1)) begin
            state_nxt   = S_TA;
            bcnt_nxt    = '0;
            mdio_o_nxt  = 1'b1;
            mdio_oe_nxt = 1'b0;
          end else begin
            bcnt_nxt   = bcnt + 5'd1;
            mdio_o_nxt = hdr_sr[13];
            hdr_sr_nxt = {hdr_sr[12:0], 1'b0};
          end
        end
      end

      S_TA: begin
        if (bit_end) begin
          if (bcnt == 5'(TA_BITS - 1)) begin
            // A PHY that answers pulls the second turnaround bit low
            state_nxt = S_DATA;
            bcnt_nxt  = '0;
            nores_nxt = mdio_s2;
            if (mdio_s2) begin
              err_nxt = 1'b1;
            end
          end else begin
            bcnt_nxt = bcnt + 5'd1;
          end
        end
      end

      S_DATA: begin
        if (bit_end) begin
          data_sr_nxt = {data_sr[14:0], mdio_s2};
          if (bcnt == 5'(DATA_BITS - 1)) begin
            state_nxt = S_NEXT;
            bcnt_nxt  = '0;
          end else begin
            bcnt_nxt = bcnt + 5'd1;
          end
        end
      end

      S_NEXT: begin
        hold1_nxt = hold1_w;
        hold2_nxt = hold2_w;
        hold3_nxt = hold3_w;
        if (last_frame) begin
          state_nxt    = S_IDLE;
          bmsr_nxt     = hold1_w;
          phyid_1_nxt  = hold2_w;
          phyid_2_nxt  = hold3_w;
          upd_nxt      = 1'b1;
          busy_nxt     = 1'b0;
          poll_cnt_nxt = '0;
        end else begin
          state_nxt   = S_PRE;
          fidx_nxt    = fidx + 2'd1;
          bcnt_nxt    = '0;
          mdio_o_nxt  = 1'b1;
          mdio_oe_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
